// File: rtl/weight_rom_sequencer.sv
// Streams OUT_DEPTH ROM words per pass, num_passes times, through a small skid FIFO with ready/valid.
// Optional `WEIGHT_SEQ_CONTINUOUS_EN: num_passes=0 streams forever until abort/rst.
module weight_rom_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int OUT_DEPTH    = 32,
  parameter int ADDR_WIDTH   = $clog2(OUT_DEPTH + 1),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [15:0]           num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int DEPTH = READ_LATENCY + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = 8;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;

  state_e                  state_q;
  logic [15:0]             passes_q, pass_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [READ_LATENCY-1:0] ifv_q, ifl_q, ifv_d, ifl_d;
  logic [DATA_WIDTH-1:0]   fifo_data_q [DEPTH];
  logic [DEPTH-1:0]        fifo_last_q;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                    done_q;

  logic          pop, push, issue, addr_end, final_pass;
  logic [OW-1:0] infl_cnt, occupancy;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rom_ce         = 1'b1;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign rom_addr       = addr_q;
  assign data_out_valid = (fifo_cnt_q != '0);
  assign data_out       = data_out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign data_out_last  = data_out_valid & fifo_last_q[rd_ptr_q];

  assign pop      = data_out_valid & data_out_ready;
  assign push     = ifv_q[READ_LATENCY-1];
  assign addr_end = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));

`ifdef WEIGHT_SEQ_CONTINUOUS_EN
  assign final_pass = (passes_q != 16'd0) && (pass_cnt_q == passes_q - 16'd1);
`else
  assign final_pass = (pass_cnt_q == passes_q - 16'd1);
`endif

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) infl_cnt = infl_cnt + OW'(ifv_q[i]);
  end

  // Words in the FIFO plus words still in the ROM pipe must never exceed the FIFO depth.
  assign occupancy  = OW'(fifo_cnt_q) + infl_cnt - OW'(pop);
  assign issue      = (state_q == S_STREAM) && !abort && (occupancy < OW'(DEPTH));
  assign ifv_d      = (ifv_q << 1) | READ_LATENCY'(issue);
  assign ifl_d      = (ifl_q << 1) | READ_LATENCY'(issue & addr_end);
  assign fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rom_q;
      fifo_last_q[wr_ptr_q] <= ifl_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q    <= S_IDLE;
      passes_q   <= '0;
      pass_cnt_q <= '0;
      addr_q     <= '0;
      ifv_q      <= '0;
      ifl_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      ifv_q      <= ifv_d;
      ifl_q      <= ifl_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            passes_q   <= num_passes;
            pass_cnt_q <= '0;
            addr_q     <= '0;
`ifdef WEIGHT_SEQ_CONTINUOUS_EN
            state_q    <= S_STREAM;
`else
            if (num_passes == 16'd0) done_q  <= 1'b1;
            else                     state_q <= S_STREAM;
`endif
          end
        end
        S_STREAM: begin
          if (issue) begin
            if (addr_end) begin
              addr_q     <= '0;
              pass_cnt_q <= pass_cnt_q + 16'd1;
              if (final_pass) state_q <= S_DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Finish on the edge that retires the last word so done follows it directly.
          if (fifo_cnt_d == '0 && ifv_d == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_rom_sequencer.sv
// Directed bench for weight_rom_sequencer: OUT_DEPTH=4, READ_LATENCY=2, ROM word = 0xA0 + address.
module tb_weight_rom_sequencer;

  localparam int DW = 8;
  localparam int OD = 4;
  localparam int AW = $clog2(OD + 1);
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, data_out_ready;
  logic [15:0]   num_passes;
  logic          busy, done, rom_ce, data_out_valid, data_out_last;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out;
  logic [DW-1:0] rom_pipe0, rom_pipe1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_rom_sequencer #(
    .DATA_WIDTH(DW), .OUT_DEPTH(OD), .ADDR_WIDTH(AW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_passes(num_passes),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_q(rom_q),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last)
  );

  // Two-stage ROM model.
  always @(posedge clk) begin
    if (rom_ce) begin
      rom_pipe0 <= 8'hA0 + {{(DW-AW){1'b0}}, rom_addr};
      rom_pipe1 <= rom_pipe0;
    end
  end
  assign rom_q = rom_pipe1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts n words with ready high, checking order and last flags, then expects done.
  task automatic collect(input string tag, input int n, input int first_idx);
    int k = 0;
    bit finished = 0;
    data_out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      if (data_out_valid) begin
        check({tag, "_data"}, 32'(data_out), 32'(8'hA0 + 8'((first_idx + k) % OD)));
        check({tag, "_last"}, 32'(data_out_last), 32'(((first_idx + k) % OD) == OD - 1));
        k++;
      end
      tick();
      if (k == n) begin
        check({tag, "_done"}, 32'(done), 32'd1);
        finished = 1;
      end
    end
    check({tag, "_count"}, 32'(k), 32'(n));
  endtask

  initial begin
    int k;
    int acc;
    bit seen_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_out_ready = 1'b1; num_passes = '0;
    tick(); tick();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_valid", 32'(data_out_valid), 32'd0);
    check("rst_last",  32'(data_out_last), 32'd0);
    check("rst_addr",  32'(rom_addr), 32'd0);
    check("rst_data",  32'(data_out), 32'd0);
    check("rst_ce",    32'(rom_ce), 32'd1);
    rst = 1'b0;
    tick();

    // Two passes with ready held high: eight back-to-back words.
    start = 1'b1; num_passes = 16'd2;
    tick();
    start = 1'b0;
    check("a_busy", 32'(busy), 32'd1);
    check("a_lat1", 32'(data_out_valid), 32'd0);
    tick();
    check("a_lat2", 32'(data_out_valid), 32'd0);
    tick();
    check("a_lat3", 32'(data_out_valid), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("a_valid", 32'(data_out_valid), 32'd1);
      check("a_data",  32'(data_out), 32'(8'hA0 + 8'(i % 4)));
      check("a_last",  32'(data_out_last), 32'((i % 4) == 3));
      check("a_nodone", 32'(done), 32'd0);
      tick();
    end
    check("a_done",   32'(done), 32'd1);
    check("a_idle",   32'(busy), 32'd0);
    check("a_vlow",   32'(data_out_valid), 32'd0);
    tick();
    check("a_done_pulse", 32'(done), 32'd0);

    // Ready toggling 1,0,1,0: order preserved, nothing lost or duplicated.
    start = 1'b1; num_passes = 16'd1;
    tick();
    start = 1'b0;
    k = 0; seen_done = 0;
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      data_out_ready = (cyc % 2 == 0);
      if (data_out_valid && k < OD) begin
        check("b_data", 32'(data_out), 32'(8'hA0 + 8'(k)));
        check("b_last", 32'(data_out_last), 32'(k == OD - 1));
        if (data_out_ready) k++;
      end
      tick();
      if (done) seen_done = 1;
    end
    check("b_count", 32'(k), 32'(OD));
    check("b_done",  32'(seen_done), 32'd1);
    data_out_ready = 1'b1;
    tick();

    // Ready low for 20 cycles: three reads go out, then issue stalls.
    data_out_ready = 1'b0;
    start = 1'b1; num_passes = 16'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("c_addr",  32'(rom_addr), 32'd3);
    check("c_valid", 32'(data_out_valid), 32'd1);
    check("c_hold",  32'(data_out), 32'hA0);
    collect("c", OD, 0);
    tick();

    // Abort after five accepted words, then restart from address 0.
    start = 1'b1; num_passes = 16'd2;
    tick();
    start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 5; cyc++) begin
      if (data_out_valid) begin
        check("d_data", 32'(data_out), 32'(8'hA0 + 8'(acc % 4)));
        acc++;
      end
      tick();
    end
    check("d_acc", 32'(acc), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("d_busy",  32'(busy), 32'd0);
    check("d_valid", 32'(data_out_valid), 32'd0);
    check("d_done",  32'(done), 32'd0);
    check("d_addr",  32'(rom_addr), 32'd0);
    tick();
    check("d_done2", 32'(done), 32'd0);
    start = 1'b1; num_passes = 16'd1;
    tick();
    start = 1'b0;
    collect("d_re", OD, 0);
    tick();

`ifndef WEIGHT_SEQ_CONTINUOUS_EN
    // Zero passes: immediate done, no reads.
    start = 1'b1; num_passes = 16'd0;
    tick();
    start = 1'b0;
    check("z_done",  32'(done), 32'd1);
    check("z_busy",  32'(busy), 32'd0);
    check("z_addr",  32'(rom_addr), 32'd0);
    tick();
    check("z_done2", 32'(done), 32'd0);
    check("z_valid", 32'(data_out_valid), 32'd0);
`else
    // Zero passes streams until aborted.
    start = 1'b1; num_passes = 16'd0;
    tick();
    start = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 100; cyc++) begin
      if (data_out_valid) begin
        check("z_data", 32'(data_out), 32'(8'hA0 + 8'(acc % 4)));
        acc++;
      end
      check("z_nodone", 32'(done), 32'd0);
      tick();
    end
    check("z_count", 32'(acc), 32'd100);
    check("z_busy",  32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("z_idle",  32'(busy), 32'd0);
`endif
    tick();

    // Reset mid-job, then start on the very first cycle afterwards.
    start = 1'b1; num_passes = 16'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("r_busy",  32'(busy), 32'd0);
    check("r_valid", 32'(data_out_valid), 32'd0);
    check("r_done",  32'(done), 32'd0);
    rst = 1'b0; start = 1'b1; num_passes = 16'd1;
    tick();
    start = 1'b0;
    check("r_start", 32'(busy), 32'd1);
    collect("r", OD, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_rom_sequencer.md
WEIGHT_ROM_SEQUENCER -- requirements
Module: weight_rom_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: ROM word / output width in bits.
REQ-002 The block SHALL have parameter OUT_DEPTH, default 32: words per pass, ROM addresses 0..OUT_DEPTH-1.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(OUT_DEPTH+1): ROM address width.
REQ-004 The block SHALL have parameter READ_LATENCY, default 2: fixed ROM read latency in cycles, range 1..4.
REQ-005 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  flush the job and return to IDLE.
- num_passes  in  16  passes per job; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a job completes.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_ce  out  1  ROM clock enable.
- rom_q  in  DATA_WIDTH  ROM read data, READ_LATENCY cycles after its address.
- data_out  out  DATA_WIDTH  streamed weight word.
- data_out_valid  out  1  data_out is valid.
- data_out_ready  in  1  consumer accepts the word.
- data_out_last  out  1  data_out is the final word of a pass.

Function
REQ-006 The block SHALL implement a state machine with states IDLE, STREAM and DRAIN.
REQ-007 In IDLE, start=1 SHALL latch num_passes; a non-zero value moves to STREAM, and zero stays in IDLE and pulses done on the next cycle without issuing any read.
REQ-008 rom_ce SHALL be held at 1 out of reset; an issue is tracked by an in-flight valid shift register of length READ_LATENCY that carries the last-word flag.
REQ-009 The output buffer SHALL be a FIFO of depth READ_LATENCY+1 written with rom_q when the in-flight tail bit is set; data_out, data_out_valid and data_out_last SHALL come from the FIFO head.
REQ-010 In STREAM, a read SHALL issue in a cycle only when fifo_count + inflight_count - pop < READ_LATENCY+1, where pop = data_out_valid & data_out_ready; this rule SHALL prevent FIFO overflow and allow one word per cycle when ready is held high.
REQ-011 The address SHALL advance only on an issue; after OUT_DEPTH-1 it SHALL wrap to 0 and increment the pass counter.
REQ-012 An issue of address OUT_DEPTH-1 SHALL set data_out_last for that word.
REQ-013 After the issue of address OUT_DEPTH-1 on the final pass, the block SHALL go to DRAIN.
REQ-014 DRAIN SHALL last until the FIFO is empty and nothing is in flight; the block SHALL then go to IDLE and pulse done for exactly one cycle.
REQ-015 The first data_out_valid SHALL rise READ_LATENCY+1 edges after the edge that samples start, provided data_out_ready is high.
REQ-016 data_out and data_out_last SHALL be held stable while data_out_valid=1 and data_out_ready=0.
REQ-017 abort in any non-IDLE state SHALL, on the next edge, clear the FIFO, the in-flight register and the counters and enter IDLE; done SHALL NOT pulse.
REQ-018 abort SHALL take priority over start; start outside IDLE SHALL be ignored.
REQ-019 rom_addr SHALL hold 0 in IDLE.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, empty FIFO, in-flight bits 0, counters 0, busy=0, done=0, data_out_valid=0, data_out_last=0, rom_addr=0 and data_out=0.
REQ-021 rst asserted mid-job SHALL behave as abort, and after rst deasserts the block SHALL accept start in the first cycle.

Configuration
REQ-022 With WEIGHT_SEQ_CONTINUOUS_EN defined, num_passes=0 SHALL mean infinite passes: the block stays in STREAM and wraps until abort or rst.
REQ-023 Without WEIGHT_SEQ_CONTINUOUS_EN, num_passes=0 SHALL behave per REQ-007, and no other behaviour SHALL change.

Verification
REQ-024 OUT_DEPTH=4, READ_LATENCY=2, ready always 1, start with num_passes=2 -> words 0,1,2,3,0,1,2,3 on 8 consecutive cycles; valid first rises 3 edges after start; last on words 3 and 7; done 1 cycle after last pop.
REQ-025 Same configuration, ready toggling 1,0,1,0 -> no word lost or duplicated, data stable while stalled, FIFO never above 3 entries.
REQ-026 ready=0 for 20 cycles after start -> exactly 3 reads issued, then issue stalls; releasing ready delivers the words in order.
REQ-027 abort asserted after 5 accepted words -> busy=0 next cycle, valid=0, no done; a new start restreams from address 0.
REQ-028 num_passes=0 -> without the macro, done pulses one cycle later with no reads; with the macro, the stream continues for 100 words until abort.
